stream_fifo: RTL

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo_pkg.sv | 9 +
 rtl/stream_fifo_ram.sv | 26 ++
 rtl/stream_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared helpers for the stream FIFO slice
package stream_fifo_pkg;

  // Next value of a sticky flag: a new set wins over a same-cycle clear.
  function automatic logic sticky_next(logic cur, logic set, logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// rtl/stream_fifo_ram.sv - one write port, one asynchronous read port storage
module stream_fifo_ram #(
  parameter int C_WIDTH   = 32,
  parameter int C_DEPTH_X = 2,
  parameter int C_DEPTH   = 2 ** C_DEPTH_X
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [C_DEPTH_X-1:0] waddr_i,
  input  logic [C_WIDTH-1:0]   din_i,
  input  logic [C_DEPTH_X-1:0] raddr_i,
  output logic [C_WIDTH-1:0]   dout_o
);

  logic [C_WIDTH-1:0] mem [C_DEPTH];

  // Storage only changes on an accepted write; no reset on the array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= din_i;
    end
  end

  assign dout_o = mem[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through stream FIFO with level and sticky error flags
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int C_FIFO_WIDTH   = 32,
  parameter int C_FIFO_DEPTH_X = 2,
  parameter int C_FIFO_DEPTH   = 2 ** C_FIFO_DEPTH_X,
  parameter int C_AFULL_LVL    = C_FIFO_DEPTH - 1,
  parameter int C_AEMPTY_LVL   = 1
) (
  input  logic                      clk_i,
  input  logic                      resetb_i,
  input  logic                      clk_en_i,
  input  logic                      flush_i,
  input  logic                      clr_err_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [C_FIFO_WIDTH-1:0]   din_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [C_FIFO_WIDTH-1:0]   dout_o,
  output logic [C_FIFO_DEPTH_X:0]   level_o,
  output logic                      afull_o,
  output logic                      aempty_o,
  output logic                      ovf_o,
  output logic                      unf_o
);

  localparam int                  LP_PTR_W  = C_FIFO_DEPTH_X + 1;
  localparam logic [LP_PTR_W-1:0] LP_ONE    = LP_PTR_W'(1);
  localparam logic [LP_PTR_W-1:0] LP_AFULL  = LP_PTR_W'(C_AFULL_LVL);
  localparam logic [LP_PTR_W-1:0] LP_AEMPTY = LP_PTR_W'(C_AEMPTY_LVL);

  // The extra MSB on each pointer tells full apart from empty.
  logic [LP_PTR_W-1:0] wr_ptr;
  logic [LP_PTR_W-1:0] rd_ptr;
  logic                full;
  logic                empty;
  logic                wr_en;
  logic                rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[C_FIFO_DEPTH_X] != rd_ptr[C_FIFO_DEPTH_X]) &&
                 (wr_ptr[C_FIFO_DEPTH_X-1:0] == rd_ptr[C_FIFO_DEPTH_X-1:0]);

  assign wr_ready_o = ~full;
  assign rd_valid_o = ~empty;

  // Full refuses writes outright, even when a read frees a slot this cycle.
  assign wr_en = clk_en_i & wr_valid_i & ~full  & ~flush_i;
  assign rd_en = clk_en_i & rd_ready_i & ~empty & ~flush_i;

  assign level_o  = wr_ptr - rd_ptr;
  assign afull_o  = (level_o >= LP_AFULL);
  assign aempty_o = (level_o <= LP_AEMPTY);

  // Pointer and sticky flag state; flush empties the queue but keeps the flags.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_o  <= 1'b0;
      unf_o  <= 1'b0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + LP_ONE;
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + LP_ONE;
        end
      end
      ovf_o <= sticky_next(ovf_o, wr_valid_i & full  & ~flush_i, clr_err_i);
      unf_o <= sticky_next(unf_o, rd_ready_i & empty & ~flush_i, clr_err_i);
    end
  end

  stream_fifo_ram #(
    .C_WIDTH   (C_FIFO_WIDTH),
    .C_DEPTH_X (C_FIFO_DEPTH_X),
    .C_DEPTH   (C_FIFO_DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr[C_FIFO_DEPTH_X-1:0]),
    .din_i   (din_i),
    .raddr_i (rd_ptr[C_FIFO_DEPTH_X-1:0]),
    .dout_o  (dout_o)
  );

endmodule
